accum_ctrl: RTL and testbench

- Sequencer for the 4-slice accumulator bank. One slice covers 4 systolic-array columns; `SUPER_SYS_COLS/4` = 4.
- Takes a tile command (K-tile count, active column count) and turns the systolic array's partial-sum strobe into per-slice `true_valid`, `overwrite` and `store`.
- Then drains the committed results with `rd_en` under downstream back-pressure.
- Sits between the GEMM top-level control FSM and the accumulator datapath.

---
 rtl/accum_ctrl_pkg.sv | 16 +
 rtl/accum_ctrl_slice_mask.sv | 21 ++
 rtl/accum_ctrl.sv | 152 +++++++++++++++
 tb/tb_accum_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_ctrl_pkg.sv
// rtl/accum_ctrl_pkg.sv - shared configuration types for the accumulator sequencer
package accum_ctrl_pkg;

    localparam int SUPER_SYS_COLS = 16;
    localparam int ACC_SLICES     = SUPER_SYS_COLS / 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        FIN
    } acc_state_e;

    typedef logic [ACC_SLICES-1:0] acc_mask_t;

endpackage

// File: rtl/accum_ctrl_slice_mask.sv
// rtl/accum_ctrl_slice_mask.sv - active-column count to accumulator slice mask decoder
module acc_slice_mask
    import accum_ctrl_pkg::*;
#(
    parameter int NS = ACC_SLICES
) (
    input  logic [4:0]    n_cols,
    output logic [NS-1:0] mask,
    output logic          cols_ok
);

    // Slice i owns columns 4*i..4*i+3 and is live when any of them is active
    always_comb begin
        mask = '0;
        for (int i = 0; i < NS; i++) begin
            mask[i] = ({27'd0, n_cols} > 32'(4 * i));
        end
        cols_ok = (n_cols != 5'd0) && ({27'd0, n_cols} <= 32'(SUPER_SYS_COLS));
    end

endmodule

// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - accumulator bank sequencer, optional ACCUM_CTRL_PERF_EN drain stall counter
module accum_ctrl
    import accum_ctrl_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int K_W  = 8,
    parameter int NS   = ACC_SLICES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K_W-1:0] k_tiles,
    input  logic [4:0]     n_cols,
    input  logic           sys_valid,
    input  logic [NS-1:0]  empty,
    input  logic           o_ready,
    output logic [NS-1:0]  true_valid,
    output logic [NS-1:0]  overwrite,
    output logic [NS-1:0]  store,
    output logic [NS-1:0]  rd_en,
    output logic           out_valid,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef ACCUM_CTRL_PERF_EN
    ,
    output logic [31:0]    stall_cycles
`endif
);

    localparam int            RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] RLAST = RW'(ROWS - 1);

    acc_state_e     state, state_nx;
    logic [NS-1:0]  mask;
    logic [NS-1:0]  cmd_mask;
    logic           cmd_ok;
    logic [K_W-1:0] kcnt, kmax;
    logic [RW-1:0]  rcnt, dcnt;
    logic           accept;
    logic           err_nx;

    acc_slice_mask #(.NS(NS)) u_mask (
        .n_cols  (n_cols),
        .mask    (cmd_mask),
        .cols_ok (cmd_ok)
    );

    // Next state, zero-latency slice strobes and protocol error detection
    always_comb begin
        state_nx   = state;
        true_valid = '0;
        overwrite  = '0;
        store      = '0;
        rd_en      = '0;
        accept     = 1'b0;
        err_nx     = 1'b0;
        busy       = (state != IDLE);
        done       = (state == FIN);
        case (state)
            IDLE: begin
                if (start) begin
                    if (cmd_ok) begin
                        accept   = 1'b1;
                        state_nx = ACCUM;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                if (sys_valid) err_nx = 1'b1;
            end
            ACCUM: begin
                if (sys_valid) begin
                    true_valid = mask;
                    if (kcnt == '0) overwrite = mask;
                    if (kcnt == kmax) store = mask;
                    if (rcnt == RLAST && kcnt == kmax) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // All active slices pop together or not at all
                if (o_ready && (empty & mask) == '0) begin
                    rd_en = mask;
                    if (dcnt == RLAST) state_nx = FIN;
                end
                if (sys_valid) err_nx = 1'b1;
            end
            FIN: begin
                state_nx = IDLE;
                if (sys_valid) err_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register plus registered out_valid/err pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= (rd_en != '0);
            err       <= err_nx;
        end
    end

    // Tile command latch and row/K-tile/drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            kmax <= '0;
            kcnt <= '0;
            rcnt <= '0;
            dcnt <= '0;
        end else begin
            if (accept) begin
                mask <= cmd_mask;
                kmax <= (k_tiles == '0) ? '0 : k_tiles - K_W'(1);
                kcnt <= '0;
                rcnt <= '0;
                dcnt <= '0;
            end else if (state == ACCUM && sys_valid) begin
                if (rcnt == RLAST) begin
                    rcnt <= '0;
                    // kcnt stays at kmax on the final wrap so kmax = all-ones cannot overflow
                    if (kcnt == kmax) dcnt <= '0;
                    else kcnt <= kcnt + K_W'(1);
                end else begin
                    rcnt <= rcnt + RW'(1);
                end
            end else if (state == DRAIN && rd_en != '0) begin
                dcnt <= dcnt + RW'(1);
            end
        end
    end

`ifdef ACCUM_CTRL_PERF_EN
    // Count drain cycles lost to back-pressure or empty slices, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if (state == DRAIN && rd_en == '0 && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accum_ctrl.sv
// tb/tb_accum_ctrl.sv - self-checking bench for accum_ctrl, covers ACCUM_CTRL_PERF_EN when defined
module tb_accum_ctrl;

    localparam int ROWS = 16;
    localparam int K_W  = 8;
    localparam int NS   = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K_W-1:0] k_tiles;
    logic [4:0]     n_cols;
    logic           sys_valid;
    logic [NS-1:0]  empty;
    logic           o_ready;
    logic [NS-1:0]  true_valid, overwrite, store, rd_en;
    logic           out_valid, busy, done, err;
`ifdef ACCUM_CTRL_PERF_EN
    logic [31:0]    stall_cycles;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    accum_ctrl #(.ROWS(ROWS), .K_W(K_W), .NS(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_tiles    (k_tiles),
        .n_cols     (n_cols),
        .sys_valid  (sys_valid),
        .empty      (empty),
        .o_ready    (o_ready),
        .true_valid (true_valid),
        .overwrite  (overwrite),
        .store      (store),
        .rd_en      (rd_en),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef ACCUM_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Reference model: a tile is ROWS*K beats, then ROWS whole-row pops, then one FIN cycle
    int            m_phase;   // 0 idle, 1 accumulating, 2 draining, 3 finishing
    int            m_beats, m_total, m_pops, m_stall;
    logic [NS-1:0] m_mask;
    logic          m_err_q, m_ov_q;
    logic [NS-1:0] e_tv, e_ow, e_st, e_rd;

    int cnt_tv, cnt_hi, cnt_rd, cnt_done;

    typedef struct {
        logic       st;
        int         k;
        int         nc;
        logic       sv;
        logic [3:0] x_tv;
        logic [3:0] x_ow;
        logic [3:0] x_st;
        logic       x_busy;
        logic       x_err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_beats = 0; m_total = 0; m_pops = 0; m_stall = 0;
        m_mask = '0; m_err_q = 1'b0; m_ov_q = 1'b0;
    endtask

    task automatic reset_counts();
        cnt_tv = 0; cnt_hi = 0; cnt_rd = 0; cnt_done = 0;
    endtask

    task automatic drive(input logic s, input int k, input int c, input logic v,
                         input logic [NS-1:0] e, input logic r);
        start = s; k_tiles = K_W'(k); n_cols = 5'(c);
        sys_valid = v; empty = e; o_ready = r;
    endtask

    task automatic observe();
        if (true_valid != '0) cnt_tv++;
        if (true_valid[3:2] != 2'b00 || overwrite[3:2] != 2'b00 ||
            store[3:2] != 2'b00 || rd_en[3:2] != 2'b00) cnt_hi++;
        if (rd_en != '0) cnt_rd++;
        if (done) cnt_done++;
    endtask

    task automatic model_eval();
        e_tv = '0; e_ow = '0; e_st = '0; e_rd = '0;
        if (m_phase == 1 && sys_valid) begin
            e_tv = m_mask;
            if (m_beats < ROWS) e_ow = m_mask;
            if (m_beats >= m_total - ROWS) e_st = m_mask;
        end
        if (m_phase == 2 && o_ready && (empty & m_mask) == '0) e_rd = m_mask;
    endtask

    task automatic model_check();
        chk("true_valid", 32'(true_valid), 32'(e_tv));
        chk("overwrite", 32'(overwrite), 32'(e_ow));
        chk("store", 32'(store), 32'(e_st));
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(m_phase == 3));
        chk("out_valid", 32'(out_valid), 32'(m_ov_q));
        chk("err", 32'(err), 32'(m_err_q));
`ifdef ACCUM_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles, 32'(m_stall));
`endif
    endtask

    task automatic model_advance();
        logic good;
        good    = (n_cols >= 5'd1) && (n_cols <= 5'd16);
        m_err_q = (m_phase == 0 && start && !good) || (sys_valid && m_phase != 1);
        m_ov_q  = (e_rd != '0);
        case (m_phase)
            0: if (start && good) begin
                m_phase = 1; m_beats = 0; m_pops = 0; m_stall = 0;
                m_total = ROWS * ((k_tiles == '0) ? 1 : int'(k_tiles));
                for (int i = 0; i < NS; i++) m_mask[i] = (int'(n_cols) > 4 * i);
            end
            1: if (sys_valid) begin
                m_beats++;
                if (m_beats == m_total) m_phase = 2;
            end
            2: begin
                if (e_rd != '0) begin
                    m_pops++;
                    if (m_pops == ROWS) m_phase = 3;
                end else begin
                    m_stall++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_rest();
        observe();
        model_eval();
        model_check();
        model_advance();
        tick();
    endtask

    task automatic cycle();
        #4;
        cycle_rest();
    endtask

    task automatic run_tile(input int nc, input int k, input int gap_pct, input int bp_pct,
                            input int emp_pct, input int junk_pct);
        int guard;
        int kk;
        logic [NS-1:0] e;
        kk = (k == 0) ? 1 : k;
        reset_counts();
        drive(1'b1, k, nc, 1'b0, '0, 1'b1);
        cycle();
        guard = 0;
        while (m_phase != 0 && guard < 3000) begin
            for (int i = 0; i < NS; i++) e[i] = ($urandom_range(99) < emp_pct);
            drive(($urandom_range(99) < 5), int'($urandom_range(255)), int'($urandom_range(31)),
                  (m_phase == 1) ? ($urandom_range(99) >= gap_pct) : ($urandom_range(99) < junk_pct),
                  e, ($urandom_range(99) >= bp_pct));
            cycle();
            guard++;
        end
        chk("tile_timeout", 32'(guard < 3000), 32'd1);
        chk("tile_beats", 32'(cnt_tv), 32'(ROWS * kk));
        chk("tile_pops", 32'(cnt_rd), 32'(ROWS));
        chk("tile_done", 32'(cnt_done), 32'd1);
        drive(1'b0, 0, 0, 1'b0, '0, 1'b1);
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic tog;

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        cycle();

        // ---------------- table: errors, command accept, ignored start ----------------
        //          st    k   nc  sv    tv     ow     st     busy  err
        tbl[0]  = '{1'b0, 1,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1,  0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1, 17, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 2,  6, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2,  6, 1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 5, 16, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 0,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};

        reset_counts();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].st, tbl[i].k, tbl[i].nc, tbl[i].sv, '0, 1'b1);
            #4;
            observe();
            chk("tbl_true_valid", 32'(true_valid), 32'(tbl[i].x_tv));
            chk("tbl_overwrite", 32'(overwrite), 32'(tbl[i].x_ow));
            chk("tbl_store", 32'(store), 32'(tbl[i].x_st));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].x_busy));
            chk("tbl_err", 32'(err), 32'(tbl[i].x_err));
            model_eval();
            model_advance();
            tick();
        end

        // ---------------- partial width, sys_valid every other cycle ----------------
        tog = 1'b1;
        guard = 0;
        while (m_phase != 0 && guard < 500) begin
            drive(1'b0, 0, 0, tog && (m_phase == 1), '0, 1'b1);
            tog = ~tog;
            cycle();
            guard++;
        end
        chk("gap_timeout", 32'(guard < 500), 32'd1);
        chk("gap_beats", 32'(cnt_tv), 32'd32);
        chk("gap_upper_slices_quiet", 32'(cnt_hi), 32'd0);
        chk("gap_pops", 32'(cnt_rd), 32'd16);
        chk("gap_done", 32'(cnt_done), 32'd1);
        drive(1'b0, 0, 0, 1'b0, '0, 1'b1);
        cycle();

        // ---------------- single K-tile and multi-K, full width, no stalls ----------------
        run_tile(16, 1, 0, 0, 0, 0);
        run_tile(16, 3, 0, 0, 0, 0);

        // ---------------- back-pressure then empty stall ----------------
        reset_counts();
        drive(1'b1, 1, 16, 1'b0, '0, 1'b0);
        cycle();
        for (int i = 0; i < ROWS; i++) begin
            drive(1'b0, 0, 0, 1'b1, '0, 1'b0);
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 0, 0, 1'b0, (i < 5) ? 4'b0000 : 4'b0010, (i >= 5));
            #4;
            chk("bp_rd_en_zero", 32'(rd_en), 32'd0);
            chk("bp_in_drain", 32'(busy), 32'd1);
            cycle_rest();
        end
        guard = 0;
        while (m_phase != 0 && guard < 100) begin
            drive(1'b0, 0, 0, 1'b0, '0, 1'b1);
            cycle();
            guard++;
        end
        chk("bp_timeout", 32'(guard < 100), 32'd1);
        chk("bp_pops", 32'(cnt_rd), 32'd16);
        chk("bp_done", 32'(cnt_done), 32'd1);
        repeat (3) begin
            drive(1'b0, 0, 0, 1'b0, '0, 1'b1);
            cycle();
        end
`ifdef ACCUM_CTRL_PERF_EN
        chk("bp_stall_cycles", stall_cycles, 32'd8);
`endif

        // ---------------- reset mid-ACCUM ----------------
        reset_counts();
        drive(1'b1, 2, 16, 1'b0, '0, 1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, 0, 1'b1, '0, 1'b1);
            cycle();
        end
        drive(1'b0, 0, 0, 1'b1, '0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_true_valid", 32'(true_valid), 32'd0);
        chk("rst_overwrite", 32'(overwrite), 32'd0);
        chk("rst_store", 32'(store), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 0, 0, 1'b0, '0, 1'b1);
        model_reset();
        repeat (4) cycle();
        chk("rst_no_done", 32'(cnt_done), 32'd0);
        run_tile(16, 2, 0, 0, 0, 0);

        // ---------------- randomized tiles and illegal commands ----------------
        for (int t = 0; t < 8; t++) begin
            drive(1'b1, 1, ($urandom_range(1) == 0) ? 0 : int'($urandom_range(31, 17)),
                  1'b0, '0, 1'b1);
            cycle();
            drive(1'b0, 0, 0, ($urandom_range(1) == 0), '0, 1'b1);
            cycle();
            drive(1'b0, 0, 0, 1'b0, '0, 1'b1);
            cycle();
            run_tile(int'($urandom_range(16, 1)), int'($urandom_range(4)), 30, 30, 10, 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
